// File: rtl/board_ram_arbiter_if.sv
// Signal bundle between the game FSM, the VGA scanner, the board RAM and board_ram_arbiter.
// The arbiter takes the slave view; requesters and the RAM take the master view.
interface board_ram_arbiter_if;
  logic       SwapReq;
  logic [2:0] SwapAX;
  logic [2:0] SwapAY;
  logic [2:0] SwapBX;
  logic [2:0] SwapBY;
  logic       RandReq;
  logic [2:0] RandX;
  logic [2:0] RandY;
  logic       GameAck;
  logic       DispReq;
  logic [2:0] DispX;
  logic [2:0] DispY;
  logic       DispValid;
  logic [2:0] DispColor;
  logic [5:0] RamAddr;
  logic       RamWe;
  logic [2:0] RamWData;
  logic [2:0] RamRData;
  logic       Busy;

  modport slave (
    input  SwapReq, SwapAX, SwapAY, SwapBX, SwapBY,
    input  RandReq, RandX, RandY,
    input  DispReq, DispX, DispY,
    input  RamRData,
    output GameAck, DispValid, DispColor,
    output RamAddr, RamWe, RamWData, Busy
  );

  modport master (
    output SwapReq, SwapAX, SwapAY, SwapBX, SwapBY,
    output RandReq, RandX, RandY,
    output DispReq, DispX, DispY,
    output RamRData,
    input  GameAck, DispValid, DispColor,
    input  RamAddr, RamWe, RamWData, Busy
  );
endinterface

// File: rtl/board_ram_arbiter.sv
// Sole master of the 8x8 board colour RAM: atomic swaps, LFSR random fills and display reads.
// Define ARB_DISPLAY_PRIORITY_EN for strict display priority; otherwise game/display round robin.
module board_ram_arbiter (
  input  logic Clk,
  input  logic Reset,
  board_ram_arbiter_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE, SW_RDA, SW_RDB, SW_WRA, SW_WRB, RND_WR, DSP_RD, DSP_DAT, ACK
  } stateT;

  stateT      state, nextState;
  logic [7:0] lfsr;
  logic       rrLast;
  logic [2:0] colA;
  logic [2:0] randColor;
  logic [2:0] dispColorQ;
  logic [2:0] wDataQ, wDataNext;
  logic [5:0] addrQ, addrNext;
  logic [5:0] addrA, addrB, randAddr, dispAddr;
  logic       weQ, weNext;
  logic       ackQ, ackNext;
  logic       validQ, validNext;
  logic       busyQ;
  logic       gameReq, grantDisp;

  assign addrA    = {bus.SwapAY, bus.SwapAX};
  assign addrB    = {bus.SwapBY, bus.SwapBX};
  assign randAddr = {bus.RandY, bus.RandX};
  assign dispAddr = {bus.DispY, bus.DispX};
  assign gameReq  = bus.SwapReq | bus.RandReq;

  // Fold 6 and 7 back onto 0 and 1 so every fill colour is in 0..5.
  assign randColor = (lfsr[2:0] >= 3'd6) ? (lfsr[2:0] - 3'd6) : lfsr[2:0];

  always_comb begin
    nextState = state;
    grantDisp = 1'b0;
    addrNext  = addrQ;
    weNext    = 1'b0;
    wDataNext = wDataQ;
    ackNext   = 1'b0;
    validNext = 1'b0;

    case (state)
      IDLE: begin
`ifdef ARB_DISPLAY_PRIORITY_EN
        grantDisp = bus.DispReq;
`else
        // rrLast high means display had the previous grant, so game wins a tie.
        grantDisp = bus.DispReq & (~gameReq | ~rrLast);
`endif
        if (grantDisp)
          nextState = DSP_RD;
        else if (gameReq)
          nextState = bus.SwapReq ? SW_RDA : RND_WR;
      end
      SW_RDA:  nextState = SW_RDB;
      SW_RDB:  nextState = SW_WRA;
      SW_WRA:  nextState = SW_WRB;
      SW_WRB:  nextState = ACK;
      RND_WR:  nextState = ACK;
      DSP_RD:  nextState = DSP_DAT;
      DSP_DAT: nextState = IDLE;
      ACK:     nextState = IDLE;
      default: nextState = IDLE;
    endcase

    // Registered outputs are loaded with the values belonging to the state being entered.
    case (nextState)
      SW_RDA:  addrNext = addrA;
      SW_RDB:  addrNext = addrB;
      SW_WRA: begin
        addrNext = addrA;
        weNext   = 1'b1;
      end
      SW_WRB: begin
        addrNext  = addrB;
        weNext    = 1'b1;
        wDataNext = colA;
      end
      RND_WR: begin
        addrNext  = randAddr;
        weNext    = 1'b1;
        wDataNext = randColor;
      end
      DSP_RD:  addrNext  = dispAddr;
      DSP_DAT: validNext = 1'b1;
      ACK:     ackNext   = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= IDLE;
      lfsr       <= 8'hA5;
      rrLast     <= 1'b1;
      colA       <= 3'd0;
      dispColorQ <= 3'd0;
      addrQ      <= 6'd0;
      weQ        <= 1'b0;
      wDataQ     <= 3'd0;
      ackQ       <= 1'b0;
      validQ     <= 1'b0;
      busyQ      <= 1'b0;
    end else begin
      state  <= nextState;
      lfsr   <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      if (state == IDLE && nextState != IDLE)
        rrLast <= grantDisp;
      if (state == SW_RDB)
        colA <= bus.RamRData;
      if (state == DSP_DAT)
        dispColorQ <= bus.RamRData;
      addrQ  <= addrNext;
      weQ    <= weNext;
      wDataQ <= wDataNext;
      ackQ   <= ackNext;
      validQ <= validNext;
      busyQ  <= (nextState != IDLE);
    end
  end

  // B's colour and the display colour only exist on the RAM's registered output in
  // SW_WRA / DSP_DAT, so those two cycles forward it; every other cycle shows the register.
  assign bus.RamAddr   = addrQ;
  assign bus.RamWe     = weQ;
  assign bus.RamWData  = (state == SW_WRA) ? bus.RamRData : wDataQ;
  assign bus.GameAck   = ackQ;
  assign bus.DispValid = validQ;
  assign bus.DispColor = (state == DSP_DAT) ? bus.RamRData : dispColorQ;
  assign bus.Busy      = busyQ;

endmodule

// File: tb/tb_board_ram_arbiter.sv
// Self-checking bench for board_ram_arbiter: behavioural RAM, reference board contents,
// reference LFSR and spec latencies; randomized ops plus directed arbitration/reset cases.
module tb_board_ram_arbiter;

`ifdef ARB_DISPLAY_PRIORITY_EN
  localparam bit displayPriority = 1'b1;
`else
  localparam bit displayPriority = 1'b0;
`endif

  logic Clk = 1'b0;
  logic Reset;
  int   asserts = 0;
  int   failures = 0;

  board_ram_arbiter_if bus ();

  board_ram_arbiter dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  // Board RAM with registered read data, plus a backdoor port for preloading.
  logic [2:0] ram [64];
  logic       bdWe = 1'b0;
  logic [5:0] bdAddr = 6'd0;
  logic [2:0] bdData = 3'd0;

  always @(posedge Clk) begin
    if (bdWe)
      ram[bdAddr] <= bdData;
    else if (bus.RamWe)
      ram[bus.RamAddr] <= bus.RamWData;
    bus.RamRData <= ram[bus.RamAddr];
  end

  // Reference LFSR: feedback is the parity of the tapped bits 8,6,5,4.
  logic [7:0] mlfsr;
  always @(posedge Clk) begin
    if (Reset) mlfsr <= 8'hA5;
    else       mlfsr <= {mlfsr[6:0], ^(mlfsr & 8'hB8)};
  end

  logic [2:0] refMem [64];

  function automatic logic [2:0] fillColor(input logic [7:0] state);
    return 3'(int'(state[2:0]) % 6);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    asserts++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic bdWrite(input logic [5:0] addr, input logic [2:0] data);
    bdWe = 1'b1; bdAddr = addr; bdData = data;
    @(negedge Clk);
    bdWe = 1'b0;
    refMem[addr] = data;
  endtask

  task automatic applyStimulus(input int kind, input logic [2:0] ax, input logic [2:0] ay,
                               input logic [2:0] bx, input logic [2:0] by);
    case (kind)
      0: begin bus.SwapAX = ax; bus.SwapAY = ay; bus.SwapBX = bx; bus.SwapBY = by; bus.SwapReq = 1'b1; end
      1: begin bus.RandX = ax; bus.RandY = ay; bus.RandReq = 1'b1; end
      default: begin bus.DispX = ax; bus.DispY = ay; bus.DispReq = 1'b1; end
    endcase
  endtask

  task automatic awaitPulse(input int kind, output int cyc, output int weCount,
                            output logic [2:0] wData, output logic [2:0] dColor);
    cyc = -1; weCount = 0; wData = 3'd0; dColor = 3'd0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge Clk);
      if (bus.RamWe) begin weCount++; wData = bus.RamWData; end
      if ((kind == 2) ? bus.DispValid : bus.GameAck) begin
        cyc = k;
        dColor = bus.DispColor;
        break;
      end
    end
    bus.SwapReq = 1'b0; bus.RandReq = 1'b0; bus.DispReq = 1'b0;
    if (cyc < 0) checkOutput("pulseTimeout", 0, 1);
  endtask

  // Issues one operation from an IDLE cycle and checks latency, RAM effect and read data.
  task automatic runOp(input int kind, input logic [2:0] ax, input logic [2:0] ay,
                       input logic [2:0] bx, input logic [2:0] by);
    int cyc, we;
    logic [2:0] wd, dc, expColor, tmp;
    logic [5:0] a, b;
    a = 6'(8 * ay + ax);
    b = 6'(8 * by + bx);
    expColor = fillColor(mlfsr);
    applyStimulus(kind, ax, ay, bx, by);
    awaitPulse(kind, cyc, we, wd, dc);
    checkOutput("busyDuringOp", bus.Busy, 1);
    case (kind)
      0: begin
        checkOutput("swapLatency", cyc, 5);
        checkOutput("swapWeCycles", we, 2);
        tmp = refMem[a]; refMem[a] = refMem[b]; refMem[b] = tmp;
        checkOutput("swapCellA", ram[a], refMem[a]);
        checkOutput("swapCellB", ram[b], refMem[b]);
      end
      1: begin
        checkOutput("fillLatency", cyc, 2);
        checkOutput("fillWeCycles", we, 1);
        checkOutput("fillColor", wd, expColor);
        checkOutput("fillRange", (wd <= 3'd5), 1);
        refMem[a] = expColor;
        checkOutput("fillCell", ram[a], refMem[a]);
      end
      default: begin
        checkOutput("dispLatency", cyc, 2);
        checkOutput("dispWeCycles", we, 0);
        checkOutput("dispColor", dc, refMem[a]);
      end
    endcase
    @(negedge Clk);
    checkOutput("busyIdle", bus.Busy, 0);
  endtask

  initial begin
    int ackCyc, validCyc, grantIdx, kind, ackSeen;
    logic [7:0] prevLfsr;
    logic [2:0] tmp;

    Reset = 1'b1;
    bus.SwapReq = 1'b0; bus.RandReq = 1'b0; bus.DispReq = 1'b0;
    bus.SwapAX = 3'd0; bus.SwapAY = 3'd0; bus.SwapBX = 3'd0; bus.SwapBY = 3'd0;
    bus.RandX = 3'd0; bus.RandY = 3'd0; bus.DispX = 3'd0; bus.DispY = 3'd0;
    repeat (2) @(negedge Clk);
    checkOutput("rstRamAddr", bus.RamAddr, 0);
    checkOutput("rstRamWe", bus.RamWe, 0);
    checkOutput("rstRamWData", bus.RamWData, 0);
    checkOutput("rstGameAck", bus.GameAck, 0);
    checkOutput("rstDispValid", bus.DispValid, 0);
    checkOutput("rstDispColor", bus.DispColor, 0);
    checkOutput("rstBusy", bus.Busy, 0);
    for (int i = 0; i < 64; i++) bdWrite(6'(i), 3'($urandom_range(0, 7)));
    bdWrite(6'd19, 3'd4);
    bdWrite(6'd20, 3'd1);
    bdWrite(6'd0, 3'd5);
    Reset = 1'b0;

    $display("[TB] directed swap (3,2)<->(4,2) and A==B swap at (0,0)");
    runOp(0, 3'd3, 3'd2, 3'd4, 3'd2);
    checkOutput("swapSpecA", ram[19], 1);
    checkOutput("swapSpecB", ram[20], 4);
    runOp(0, 3'd0, 3'd0, 3'd0, 3'd0);
    checkOutput("swapSameCell", ram[0], 5);

    $display("[TB] 200 random fills at (7,7)");
    for (int i = 0; i < 200; i++) runOp(1, 3'd7, 3'd7, 3'd0, 3'd0);

    $display("[TB] randomized mixed operations");
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 2);
      runOp(kind, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                  3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    end

    $display("[TB] simultaneous swap and display request from reset");
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    applyStimulus(0, 3'd1, 3'd1, 3'd2, 3'd1);
    applyStimulus(2, 3'd5, 3'd5, 3'd0, 3'd0);
    ackCyc = -1; validCyc = -1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge Clk);
      if (bus.GameAck && ackCyc < 0) begin ackCyc = k; bus.SwapReq = 1'b0; end
      if (bus.DispValid && validCyc < 0) begin
        validCyc = k;
        checkOutput("simDispColor", bus.DispColor, refMem[45]);
        bus.DispReq = 1'b0;
      end
      if (ackCyc >= 0 && validCyc >= 0) break;
    end
    checkOutput("simAckCycle", ackCyc, displayPriority ? 8 : 5);
    checkOutput("simValidCycle", validCyc, displayPriority ? 2 : 8);
    tmp = refMem[9]; refMem[9] = refMem[10]; refMem[10] = tmp;
    checkOutput("simSwapA", ram[9], refMem[9]);
    checkOutput("simSwapB", ram[10], refMem[10]);
    @(negedge Clk);

    $display("[TB] display and fill requests held together");
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    applyStimulus(2, 3'd3, 3'd3, 3'd0, 3'd0);
    applyStimulus(1, 3'd6, 3'd0, 3'd0, 3'd0);
    prevLfsr = mlfsr;
    grantIdx = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge Clk);
      if (bus.RamWe) begin
        checkOutput("rrFillColor", bus.RamWData, fillColor(prevLfsr));
        refMem[6] = fillColor(prevLfsr);
      end
      if (bus.GameAck || bus.DispValid) begin
        checkOutput("rrGrantSide", bus.DispValid, displayPriority ? 1 : (grantIdx % 2));
        if (bus.DispValid) checkOutput("rrDispColor", bus.DispColor, refMem[27]);
        grantIdx++;
      end
      prevLfsr = mlfsr;
    end
    bus.DispReq = 1'b0; bus.RandReq = 1'b0;
    checkOutput("rrGrantCount", (grantIdx >= 10), 1);
    repeat (6) @(negedge Clk);

    $display("[TB] reset pulsed during SW_WRA");
    applyStimulus(0, 3'd0, 3'd1, 3'd1, 3'd1);
    repeat (3) @(negedge Clk);
    checkOutput("midOpWriteA", bus.RamWe, 1);
    Reset = 1'b1;
    bus.SwapReq = 1'b0;
    @(negedge Clk);
    checkOutput("midRstRamWe", bus.RamWe, 0);
    checkOutput("midRstBusy", bus.Busy, 0);
    checkOutput("midRstAddr", bus.RamAddr, 0);
    checkOutput("midRstLfsr", dut.lfsr, 8'hA5);
    Reset = 1'b0;
    ackSeen = 0;
    for (int k = 0; k < 8; k++) begin
      if (bus.GameAck) ackSeen = 1;
      @(negedge Clk);
    end
    checkOutput("midRstNoAck", ackSeen, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule
